amba_axi4_lite_txn_monitor: RTL and testbench

AMBA_AXI4_LITE_TXN_MONITOR -- requirements
Module: amba_axi4_lite_txn_monitor

---
 rtl/amba_axi4_lite_monitor_pkg.sv | 21 ++
 rtl/amba_axi4_lite_stall_timer.sv | 45 ++++
 rtl/amba_axi4_lite_txn_monitor.sv | 192 +++++++++++++++++++
 tb/tb_amba_axi4_lite_txn_monitor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/amba_axi4_lite_monitor_pkg.sv
// Shared constants for the AXI4-Lite transaction monitor: ERR bit positions and RESP codes.
package amba_axi4_lite_monitor_pkg;

    localparam int ERR_W = 9;

    localparam int ERR_AW_STALL  = 0;
    localparam int ERR_W_STALL   = 1;
    localparam int ERR_B_STALL   = 2;
    localparam int ERR_AR_STALL  = 3;
    localparam int ERR_R_STALL   = 4;
    localparam int ERR_ORPHAN_B  = 5;
    localparam int ERR_ORPHAN_R  = 6;
    localparam int ERR_OVERFLOW  = 7;
    localparam int ERR_STABILITY = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/amba_axi4_lite_stall_timer.sv
// Per-channel stall timer: counts consecutive VALID && !READY cycles and emits a
// one-cycle TIMEOUT pulse on the edge where the count reaches MAXWAIT (MAXWAIT=0 disables).
module amba_axi4_lite_stall_timer #(
    parameter int MAXWAIT = 16
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic VALID,
    input  logic READY,
    output logic TIMEOUT
);

    generate
        if (MAXWAIT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{ACLK, ARESET, VALID, READY};
            assign TIMEOUT = 1'b0;
        end else begin : g_on
            localparam int TW = $clog2(MAXWAIT + 1);
            logic [TW-1:0] count;
            logic          timeout_q;
            logic          stalled;

            assign stalled = VALID && !READY;

            // Pulse fires on the edge that makes count == MAXWAIT, so the
            // sticky error lands one edge later.
            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    count     <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    timeout_q <= stalled && (count == TW'(MAXWAIT - 1));
                    if (!stalled)
                        count <= '0;
                    else if (count != TW'(MAXWAIT))
                        count <= count + TW'(1);
                end
            end

            assign TIMEOUT = timeout_q;
        end
    endgenerate

endmodule

// File: rtl/amba_axi4_lite_txn_monitor.sv
// Passive AXI4-Lite protocol monitor: outstanding/completed counters, stall timers and
// sticky error flags. Optional payload stability checking via AXI4LITE_MON_STABILITY_CHECK_EN.
module amba_axi4_lite_txn_monitor
    import amba_axi4_lite_monitor_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int MAXWAIT         = 16,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDRESS_WIDTH-1:0] AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     AWVALID,
    input  logic                     AWREADY,
    input  logic [DATA_WIDTH-1:0]    WDATA,
    input  logic [STRB_WIDTH-1:0]    WSTRB,
    input  logic                     WVALID,
    input  logic                     WREADY,
    input  logic [1:0]               BRESP,
    input  logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ADDRESS_WIDTH-1:0] ARADDR,
    input  logic [2:0]               ARPROT,
    input  logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [DATA_WIDTH-1:0]    RDATA,
    input  logic [1:0]               RRESP,
    input  logic                     RVALID,
    input  logic                     RREADY,
    input  logic                     ERR_CLR,
    output logic [ERR_W-1:0]         ERR,
    output logic                     IRQ,
    output logic [CW-1:0]            WR_PENDING,
    output logic [CW-1:0]            RD_PENDING,
    output logic [31:0]              WR_DONE,
    output logic [31:0]              RD_DONE
);

    // Channel index i matches stall error bit i (AW, W, B, AR, R).
    logic [4:0] ch_valid, ch_ready, timeout;
    assign ch_valid = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
    assign ch_ready = {RREADY, ARREADY, BREADY, WREADY, AWREADY};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_timer
            amba_axi4_lite_stall_timer #(.MAXWAIT(MAXWAIT)) u_timer (
                .ACLK    (ACLK),
                .ARESET  (ARESET),
                .VALID   (ch_valid[gi]),
                .READY   (ch_ready[gi]),
                .TIMEOUT (timeout[gi])
            );
        end
    endgenerate

    logic [CW-1:0]    awc, wc, rdp;
    logic [CW-1:0]    awc_nxt, wc_nxt, rdp_nxt;
    logic             awc_ovf, wc_ovf, rdp_ovf;
    logic             hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic             b_legal, r_legal;
    logic             stab_err;
    logic [ERR_W-1:0] err_q, err_set;
    logic [31:0]      wr_done_q, rd_done_q;

    // Returns {overflow, next}; simultaneous inc and dec cancel out.
    function automatic logic [CW:0] cnt_step(input logic [CW-1:0] cnt,
                                             input logic inc, input logic dec);
        logic [CW-1:0] nxt;
        logic          ovf;
        nxt = cnt;
        ovf = 1'b0;
        if (inc && !dec) begin
            if (cnt == CW'(MAX_OUTSTANDING))
                ovf = 1'b1;
            else
                nxt = cnt + CW'(1);
        end else if (dec && !inc) begin
            nxt = cnt - CW'(1);
        end
        return {ovf, nxt};
    endfunction

    assign hs_aw = AWVALID && AWREADY;
    assign hs_w  = WVALID && WREADY;
    assign hs_b  = BVALID && BREADY;
    assign hs_ar = ARVALID && ARREADY;
    assign hs_r  = RVALID && RREADY;

    // Legality uses the registered counts only: a same-cycle AW/W cannot cover a B.
    assign b_legal = hs_b && (awc != '0) && (wc != '0);
    assign r_legal = hs_r && (rdp != '0);

    always_comb begin
        {awc_ovf, awc_nxt} = cnt_step(awc, hs_aw, b_legal);
        {wc_ovf,  wc_nxt}  = cnt_step(wc,  hs_w,  b_legal);
        {rdp_ovf, rdp_nxt} = cnt_step(rdp, hs_ar, r_legal);
        err_set                = '0;
        err_set[ERR_AW_STALL]  = timeout[0];
        err_set[ERR_W_STALL]   = timeout[1];
        err_set[ERR_B_STALL]   = timeout[2];
        err_set[ERR_AR_STALL]  = timeout[3];
        err_set[ERR_R_STALL]   = timeout[4];
        err_set[ERR_ORPHAN_B]  = hs_b && !b_legal;
        err_set[ERR_ORPHAN_R]  = hs_r && !r_legal;
        err_set[ERR_OVERFLOW]  = awc_ovf || wc_ovf || rdp_ovf;
        err_set[ERR_STABILITY] = stab_err;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awc       <= '0;
            wc        <= '0;
            rdp       <= '0;
            wr_done_q <= '0;
            rd_done_q <= '0;
            err_q     <= '0;
        end else begin
            awc       <= awc_nxt;
            wc        <= wc_nxt;
            rdp       <= rdp_nxt;
            wr_done_q <= wr_done_q + 32'(b_legal);
            rd_done_q <= rd_done_q + 32'(r_legal);
            // A fresh error in the clear cycle survives the clear.
            err_q     <= (ERR_CLR ? '0 : err_q) | err_set;
        end
    end

`ifdef AXI4LITE_MON_STABILITY_CHECK_EN
    localparam int AP = ADDRESS_WIDTH + 3;
    localparam int WP = DATA_WIDTH + STRB_WIDTH;
    localparam int RP = DATA_WIDTH + 2;
    localparam int PW = (AP > WP) ? ((AP > RP) ? AP : RP) : ((WP > RP) ? WP : RP);

    logic [PW-1:0] payload [5];
    logic [PW-1:0] cap     [5];
    logic [4:0]    armed;

    assign payload[0] = PW'({AWADDR, AWPROT});
    assign payload[1] = PW'({WDATA, WSTRB});
    assign payload[2] = PW'(BRESP);
    assign payload[3] = PW'({ARADDR, ARPROT});
    assign payload[4] = PW'({RDATA, RRESP});

    always_comb begin
        stab_err = 1'b0;
        for (int i = 0; i < 5; i++)
            if (armed[i] && (!ch_valid[i] || (payload[i] != cap[i])))
                stab_err = 1'b1;
    end

    // Arm on the first stalled cycle; keep tracking the latest payload so each
    // change is reported against its predecessor.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            armed <= '0;
            for (int i = 0; i < 5; i++)
                cap[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!armed[i]) begin
                    if (ch_valid[i] && !ch_ready[i]) begin
                        armed[i] <= 1'b1;
                        cap[i]   <= payload[i];
                    end
                end else if (!ch_valid[i] || ch_ready[i]) begin
                    armed[i] <= 1'b0;
                end else begin
                    cap[i] <= payload[i];
                end
            end
        end
    end
`else
    logic unused_payload;
    assign unused_payload = ^{AWADDR, AWPROT, WDATA, WSTRB, BRESP,
                              ARADDR, ARPROT, RDATA, RRESP};
    assign stab_err = 1'b0;
`endif

    assign ERR        = err_q;
    assign IRQ        = |err_q;
    assign WR_PENDING = (awc < wc) ? awc : wc;
    assign RD_PENDING = rdp;
    assign WR_DONE    = wr_done_q;
    assign RD_DONE    = rd_done_q;

endmodule

// File: tb/tb_amba_axi4_lite_txn_monitor.sv
// Directed scoreboard bench for amba_axi4_lite_txn_monitor; expectations follow
// AXI4LITE_MON_STABILITY_CHECK_EN when it is defined.
module tb_amba_axi4_lite_txn_monitor;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 8;
    localparam int MW = 16;
    localparam int CW = $clog2(MO + 1);
    localparam int EW = 10 + 2 * CW + 64;
`ifdef AXI4LITE_MON_STABILITY_CHECK_EN
    localparam logic [8:0] STAB = 9'h100;
`else
    localparam logic [8:0] STAB = 9'h000;
`endif

    logic          ACLK, ARESET;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [DW/8-1:0] WSTRB;
    logic [1:0]    BRESP, RRESP;
    logic          ERR_CLR;
    logic [8:0]    ERR;
    logic          IRQ;
    logic [CW-1:0] WR_PENDING, RD_PENDING;
    logic [31:0]   WR_DONE, RD_DONE;

    logic [EW-1:0] exp_q[$];
    string         tag_q[$];
    int            checks = 0;
    int            failures = 0;

    amba_axi4_lite_txn_monitor #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .MAXWAIT(MW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .ERR_CLR(ERR_CLR), .ERR(ERR), .IRQ(IRQ),
        .WR_PENDING(WR_PENDING), .RD_PENDING(RD_PENDING),
        .WR_DONE(WR_DONE), .RD_DONE(RD_DONE)
    );

    // Clock / reset
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic idle();
        AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; BVALID = 0; BREADY = 0;
        ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; ERR_CLR = 0;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic r);
        case (ch)
            0: begin AWVALID = v; AWREADY = r; end
            1: begin WVALID  = v; WREADY  = r; end
            2: begin BVALID  = v; BREADY  = r; end
            3: begin ARVALID = v; ARREADY = r; end
            default: begin RVALID = v; RREADY = r; end
        endcase
    endtask

    task automatic expect_out(input string tag, input logic [8:0] err,
                              input int wrp, input int rdp,
                              input logic [31:0] wrd, input logic [31:0] rdd);
        exp_q.push_back({|err, err, CW'(wrp), CW'(rdp), wrd, rdd});
        tag_q.push_back(tag);
    endtask

    // Scoreboard: pops every pending expectation away from the active edge
    task automatic check_field(input string tag, input string field,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, field, act, exp);
        end
    endtask

    always @(negedge ACLK) begin : monitor
        logic [EW-1:0] e;
        string t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_field(t, "irq",        32'(IRQ),        32'(e[EW-1]));
            check_field(t, "err",        32'(ERR),        32'(e[64+2*CW +: 9]));
            check_field(t, "wr_pending", 32'(WR_PENDING), 32'(e[64+CW +: CW]));
            check_field(t, "rd_pending", 32'(RD_PENDING), 32'(e[64 +: CW]));
            check_field(t, "wr_done",    WR_DONE,         e[63:32]);
            check_field(t, "rd_done",    RD_DONE,         e[31:0]);
        end
    end

    initial begin
        int chans[4] = '{0, 1, 2, 4};
        logic [8:0] e;
        ARESET = 1; idle();
        AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
        WDATA = 32'h1234_5678; WSTRB = '1; RDATA = 32'hCAFE_0000; BRESP = 2'b00; RRESP = 2'b00;
        cyc(2); expect_out("reset", 0, 0, 0, 0, 0);
        ARESET = 0;

        // basic write: AW+W then B two cycles later
        set_ch(0, 1, 1); set_ch(1, 1, 1); cyc(1); idle(); expect_out("wr_pend", 0, 1, 0, 0, 0);
        cyc(1);
        set_ch(2, 1, 1); cyc(1); idle(); expect_out("wr_done", 0, 0, 0, 1, 0);
        // AW and W on different cycles: pending is the min
        set_ch(0, 1, 1); cyc(1); idle(); expect_out("aw_only", 0, 0, 0, 1, 0);
        set_ch(1, 1, 1); cyc(1); idle(); expect_out("w_after", 0, 1, 0, 1, 0);
        set_ch(2, 1, 1); cyc(1); idle(); expect_out("wr_done2", 0, 0, 0, 2, 0);

        // orphan B, clear, same-cycle AW/W/B, clear-vs-new
        set_ch(2, 1, 1); cyc(1); idle(); expect_out("orphan_b", 9'h020, 0, 0, 2, 0);
        ERR_CLR = 1; cyc(1); idle(); expect_out("err_clr", 0, 0, 0, 2, 0);
        set_ch(0, 1, 1); set_ch(1, 1, 1); set_ch(2, 1, 1); cyc(1); idle();
        expect_out("b_same_cyc", 9'h020, 1, 0, 2, 0);
        ERR_CLR = 1; set_ch(2, 1, 1); cyc(1); idle(); expect_out("clr_legal_b", 0, 0, 0, 3, 0);
        ERR_CLR = 1; set_ch(2, 1, 1); cyc(1); idle(); expect_out("clr_vs_new", 9'h020, 0, 0, 3, 0);
        ERR_CLR = 1; cyc(1); idle(); expect_out("clr2", 0, 0, 0, 3, 0);

        // AR stall: 16 stalled cycles, error visible one edge later
        set_ch(3, 1, 0); cyc(16); expect_out("ar_stall16", 0, 0, 0, 3, 0);
        set_ch(3, 1, 1); cyc(1); idle(); expect_out("ar_stall17", 9'h008, 0, 1, 3, 0);
        set_ch(4, 1, 1); cyc(1); idle(); expect_out("r_legal", 9'h008, 0, 0, 3, 1);
        ERR_CLR = 1; cyc(1); idle();
        set_ch(3, 1, 0); cyc(15); set_ch(3, 1, 1); cyc(1); idle(); cyc(2);
        expect_out("ar_stall15", 0, 0, 1, 3, 1);
        set_ch(4, 1, 1); cyc(1); idle(); expect_out("r_legal2", 0, 0, 0, 3, 2);

        // overflow at MAX_OUTSTANDING, then simultaneous AR/R at full
        set_ch(3, 1, 1); cyc(8); expect_out("ar_8", 0, 0, 8, 3, 2);
        cyc(1); idle(); expect_out("ar_9", 9'h080, 0, 8, 3, 2);
        ERR_CLR = 1; cyc(1); idle();
        set_ch(3, 1, 1); set_ch(4, 1, 1); cyc(1); idle(); expect_out("ar_r_full", 0, 0, 8, 3, 3);
        set_ch(4, 1, 1); cyc(8); idle(); expect_out("r_drain", 0, 0, 0, 3, 11);
        set_ch(4, 1, 1); cyc(1); idle(); expect_out("orphan_r", 9'h040, 0, 0, 3, 11);
        ERR_CLR = 1; cyc(1); idle();

        // reset mid-transaction with handshakes during reset ignored
        set_ch(3, 1, 1); cyc(3); idle(); expect_out("rd3", 0, 0, 3, 3, 11);
        set_ch(0, 1, 1); cyc(1); idle();
        set_ch(2, 1, 1); cyc(1); idle(); expect_out("orphan_b2", 9'h020, 0, 3, 3, 11);
        ARESET = 1; set_ch(3, 1, 1); set_ch(4, 1, 1); cyc(1); idle();
        expect_out("mid_reset", 0, 0, 0, 0, 0);
        ARESET = 0;
        set_ch(4, 1, 1); cyc(1); idle(); expect_out("r_after_rst", 9'h040, 0, 0, 0, 0);
        set_ch(2, 1, 1); cyc(1); idle(); expect_out("b_after_rst", 9'h060, 0, 0, 0, 0);
        ERR_CLR = 1; cyc(1); idle();

        // AWADDR changes while stalled
        AWADDR = 32'h100; set_ch(0, 1, 0); cyc(1);
        AWADDR = 32'h104; cyc(1); expect_out("aw_change", STAB, 0, 0, 0, 0);
        set_ch(0, 1, 1); cyc(1); idle(); expect_out("aw_hs", STAB, 0, 0, 0, 0);
        ERR_CLR = 1; cyc(1); idle();

        // stall timers on the remaining channels
        foreach (chans[k]) begin
            e = 9'd1 << chans[k];
            set_ch(chans[k], 1, 0); cyc(17);
            expect_out($sformatf("stall_ch%0d", chans[k]), e, 0, 0, 0, 0);
            idle(); cyc(1);
            ERR_CLR = 1; cyc(1); idle();
        end
        expect_out("final", 0, 0, 0, 0, 0);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
